// File: rtl/alarm_clock_pkg.sv
// rtl/alarm_clock_pkg.sv - shared key codes, scanner FSM states and keypad layout helper
package alarm_clock_pkg;

  localparam logic [3:0] KEY_NONE = 4'hA;
  localparam logic [3:0] KEY_STAR = 4'hB;
  localparam logic [3:0] KEY_HASH = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_t;

  // Rows 0..2 hold digits 1..9 left to right; row 3 is "* 0 #".
  function automatic logic [3:0] key_at(input logic [1:0] row, input logic [1:0] col);
    if (row == 2'd3) begin
      case (col)
        2'd0:    key_at = KEY_STAR;
        2'd1:    key_at = 4'd0;
        default: key_at = KEY_HASH;
      endcase
    end else begin
      key_at = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// rtl/keypad_decode.sv - maps one column's active rows to a key code and a hit count
module keypad_decode
  import alarm_clock_pkg::*;
(
  input  logic [1:0] col,
  input  logic [3:0] rows,
  output logic [3:0] code,
  output logic [2:0] hits
);

  always_comb begin
    code = KEY_NONE;
    hits = 3'd0;
    for (int r = 3; r >= 0; r--) begin
      if (rows[r]) begin
        hits = hits + 3'd1;
        code = key_at(2'(r), col);
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 keypad column scanner with whole-scan press/release debounce
module keypad_scanner
  import alarm_clock_pkg::*;
#(
  parameter int SCAN_CYCLES    = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic          last_dwell, scan_done;
  logic [3:0]    dec_code, acc_code, result;
  logic [2:0]    dec_hits;
  logic [3:0]    acc_hits, total_hits;

  scan_state_t   state, state_nx;
  logic [3:0]    cand, cand_nx, key_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic          valid_nx;

  always_ff @(posedge clock) begin
    if (reset) begin
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
      dwell   <= '0;
      col_idx <= 2'd0;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
      if (last_dwell) begin
        dwell   <= '0;
        col_idx <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  assign last_dwell = (dwell == DW'(SCAN_CYCLES - 1));
  assign scan_done  = last_dwell && (col_idx == 2'd2);
  assign col_n      = (col_idx == 2'd0) ? 3'b110 : (col_idx == 2'd1) ? 3'b101 : 3'b011;

  keypad_decode u_decode (
    .col  (col_idx),
    .rows (~row_s2),
    .code (dec_code),
    .hits (dec_hits)
  );

  // The code is only trusted when the whole scan saw exactly one hit, so the
  // most recent column with any hit carries the answer.
  always_comb begin
    total_hits = acc_hits + {1'b0, dec_hits};
    result     = KEY_NONE;
    if (total_hits == 4'd1) result = (dec_hits != 3'd0) ? dec_code : acc_code;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_hits <= 4'd0;
      acc_code <= KEY_NONE;
    end else if (last_dwell) begin
      if (col_idx == 2'd0) begin
        acc_hits <= {1'b0, dec_hits};
        acc_code <= dec_code;
      end else begin
        acc_hits <= total_hits;
        if (dec_hits != 3'd0) acc_code <= dec_code;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      cand      <= KEY_NONE;
      cnt       <= '0;
      key       <= KEY_NONE;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cand      <= cand_nx;
      cnt       <= cnt_nx;
      key       <= key_nx;
      key_valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    cnt_nx   = cnt;
    key_nx   = key;
    valid_nx = 1'b0;
    cnt_inc  = cnt + CW'(1);
    if (scan_done) begin
      case (state)
        ST_IDLE: if (result != KEY_NONE) begin
          if (DEBOUNCE_SCANS == 1) begin
            state_nx = ST_PRESSED;
            key_nx   = result;
            valid_nx = 1'b1;
          end else begin
            state_nx = ST_DEBOUNCE;
            cand_nx  = result;
            cnt_nx   = CW'(1);
          end
        end
        ST_DEBOUNCE: if (result == cand) begin
          if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
            state_nx = ST_PRESSED;
            key_nx   = cand;
            valid_nx = 1'b1;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end else begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
        ST_PRESSED: if (result == KEY_NONE) begin
          if (DEBOUNCE_SCANS == 1) begin
            state_nx = ST_IDLE;
            key_nx   = KEY_NONE;
          end else begin
            state_nx = ST_RELEASE;
            cnt_nx   = CW'(1);
          end
        end
        ST_RELEASE: if (result == KEY_NONE) begin
          if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
            state_nx = ST_IDLE;
            key_nx   = KEY_NONE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end else begin
          state_nx = ST_PRESSED;
          cnt_nx   = '0;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    key_held = (state == ST_PRESSED) || (state == ST_RELEASE);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner with a keypad matrix model
module tb_keypad_scanner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic [11:0] pressed = 12'd0;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int doubles = 0;
  logic [3:0] last_key = 4'hF;
  logic prev_v = 1'b0;

  localparam int K1 = 0, K3 = 2, K5 = 4, K8 = 7, KSTAR = 9, K0 = 10, KHASH = 11;

  keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_SCANS(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clock = ~clock;

  // Bit r*3+c of pressed shorts row r to column c.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!col_n[c] && pressed[r*3+c]) row_n[r] = 1'b0;
  end

  always @(negedge clock) begin
    if (key_valid) begin
      pulses = pulses + 1;
      last_key = key;
      if (prev_v) doubles = doubles + 1;
    end
    prev_v = key_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Returns at the negedge inside the first cycle of a scan (column 0, dwell 0).
  task automatic next_scan();
    logic [2:0] prev;
    bit found;
    prev = col_n;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (prev == 3'b011 && col_n == 3'b110) found = 1;
      prev = col_n;
    end
    if (!found) check("scan_sync", 32'd0, 32'd1);
  endtask

  initial begin
    logic [2:0] pat [3];
    int p0;
    pat[0] = 3'b110; pat[1] = 3'b101; pat[2] = 3'b011;

    tick(3);
    check("rst_col", col_n, 3'b110);
    check("rst_key", key, 4'hA);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 100; i++) begin
      check("idle_col", col_n, pat[(i/4)%3]);
      @(negedge clock);
    end
    check("idle_key", key, 4'hA);
    check("idle_pulses", pulses, 0);

    // "8": press at a scan start, pulse on the 37th cycle counted from it.
    next_scan();
    p0 = pulses;
    pressed = 12'd1 << K8;
    tick(35);
    check("k8_early", key_valid, 1'b0);
    tick(1);
    check("k8_valid", key_valid, 1'b1);
    check("k8_key", key, 4'd8);
    check("k8_held", key_held, 1'b1);
    tick(30);
    check("k8_pulses", pulses - p0, 1);
    check("k8_hold_key", key, 4'd8);
    next_scan();
    pressed = 12'd0;
    tick(35);
    check("k8_rel_key_early", key, 4'd8);
    check("k8_rel_held", key_held, 1'b1);
    tick(1);
    check("k8_rel_key", key, 4'hA);
    check("k8_rel_held_off", key_held, 1'b0);
    check("k8_rel_pulses", pulses - p0, 1);

    // "5" bounce: 2 scans on, 1 off, then held.
    next_scan();
    p0 = pulses;
    pressed = 12'd1 << K5;
    tick(24);
    pressed = 12'd0;
    tick(12);
    pressed = 12'd1 << K5;
    tick(35);
    check("k5_bounce_pulses", pulses - p0, 0);
    tick(1);
    check("k5_valid", key_valid, 1'b1);
    check("k5_key", key, 4'd5);
    pressed = 12'd0;
    tick(60);
    check("k5_pulses", pulses - p0, 1);
    check("k5_rel_key", key, 4'hA);

    // "1" and "#" together for 10 scans.
    p0 = pulses;
    pressed = (12'd1 << K1) | (12'd1 << KHASH);
    tick(120);
    check("multi_pulses", pulses - p0, 0);
    check("multi_key", key, 4'hA);
    check("multi_held", key_held, 1'b0);
    pressed = 12'd0;
    tick(48);

    // Hold "0", add "3", release both, then "3" alone.
    next_scan();
    p0 = pulses;
    pressed = 12'd1 << K0;
    tick(36);
    check("k0_valid", key_valid, 1'b1);
    check("k0_key", key, 4'd0);
    tick(7);
    pressed = pressed | (12'd1 << K3);
    tick(60);
    check("k0k3_pulses", pulses - p0, 1);
    check("k0k3_last_key", last_key, 4'd0);
    pressed = 12'd0;
    tick(60);
    check("k0k3_rel_key", key, 4'hA);
    next_scan();
    pressed = 12'd1 << K3;
    tick(36);
    check("k3_valid", key_valid, 1'b1);
    check("k3_key", key, 4'd3);
    tick(5);
    check("k3_pulses", pulses - p0, 2);
    pressed = 12'd0;
    tick(60);

    // Reset while "*" is held, then re-detection.
    next_scan();
    pressed = 12'd1 << KSTAR;
    tick(36);
    check("star_valid", key_valid, 1'b1);
    check("star_key", key, 4'hB);
    tick(5);
    p0 = pulses;
    reset = 1'b1;
    tick(1);
    check("mid_rst_col", col_n, 3'b110);
    check("mid_rst_key", key, 4'hA);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_held", key_held, 1'b0);
    reset = 1'b0;
    tick(35);
    check("star_re_early", pulses - p0, 0);
    tick(1);
    check("star_re_valid", key_valid, 1'b1);
    check("star_re_key", key, 4'hB);
    tick(30);
    check("star_re_pulses", pulses - p0, 1);
    pressed = 12'd0;
    tick(60);

    check("no_double_valid", doubles, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix keypad scanner producing the 4-bit `key` code that the display and time-setting logic consume. It drives a 4x3 keypad column by column, samples the rows, debounces across whole scans and reports each new press as a one-cycle `key_valid` pulse. While a key is held, `key` holds that code; otherwise it holds `KEY_NONE`. It sits between the keypad pins and the key buffer and alarm controller.

## Interface
- `SCAN_CYCLES`, 4: clock cycles each column is driven. Minimum 3.
- `DEBOUNCE_SCANS`, 3: consecutive identical full-scan results needed to accept a press or a release. Minimum 1.
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high.
- `row_n`  in  4  keypad rows, active-low, asynchronous to `clock`.
- `col_n`  out  3  keypad column drive, active-low, exactly one bit low at any time.
- `key`  out  4  debounced key code: 0–9 for digits, `KEY_STAR`, `KEY_HASH`, or `KEY_NONE`.
- `key_valid`  out  1  one-cycle pulse for each accepted press.
- `key_held`  out  1  high while the FSM is in PRESSED or RELEASE.

## Operation
- Keypad layout (row, col):
  - row 0: 1 2 3
  - row 1: 4 5 6
  - row 2: 7 8 9
  - row 3: `*` 0 `#`
- Key codes: `KEY_NONE` = 4'hA, `KEY_STAR` = 4'hB, `KEY_HASH` = 4'hC.
- `row_n` passes through a two-flop synchronizer before any use.
- Column scan:
  - A dwell counter counts 0..SCAN_CYCLES-1. On wrap, the active column advances 0→1→2→0.
  - Column c is active when `col_n[c]` = 0.
  - Synchronized rows are sampled on the last dwell cycle of each column.
- Scan result, formed at the sample point of column 2:
  - Exactly one active row across the whole scan gives that key's code.
  - No active row gives `KEY_NONE`.
  - Two or more active row/column hits (multi-press) also give `KEY_NONE`.
- FSM, evaluated once per scan result:
  - IDLE: result ≠ NONE → DEBOUNCE, `cand` = result, `cnt` = 1.
  - DEBOUNCE:
    - result == `cand` → `cnt`++.
    - When `cnt` reaches DEBOUNCE_SCANS → PRESSED, set `key` = `cand`, pulse `key_valid`.
    - result ≠ `cand` → IDLE.
  - PRESSED:
    - result == NONE → RELEASE, `cnt` = 1.
    - Any other result, including a different key, → stay. A new key requires a full release first.
  - RELEASE:
    - result == NONE → `cnt`++.
    - When `cnt` reaches DEBOUNCE_SCANS → IDLE, `key` = `KEY_NONE`.
    - result ≠ NONE → PRESSED, with no new `key_valid`.
- DEBOUNCE_SCANS = 1 skips the counting:
  - IDLE goes straight to PRESSED.
  - PRESSED goes straight to IDLE.
- `key_held` = (state == PRESSED || state == RELEASE).

## Timing
- Reset values:
  - `col_n` = 3'b110
  - dwell counter = 0
  - `key` = `KEY_NONE`
  - `key_valid` = 0
  - state IDLE, `cnt` = 0
  - synchronizer flops all ones
- Reset mid-operation returns everything to the reset values on the next edge. A key still held after reset is re-detected and re-debounced, producing one new `key_valid`.
- One full scan takes 3·SCAN_CYCLES cycles.
- Synchronizer latency is 2 cycles. Pins must therefore settle within SCAN_CYCLES−2 cycles of a column change.
- `key`, `key_valid` and state update on the cycle after the column-2 sample. `key` and `key_valid` change on the same edge.
- Press latency: from the start of the first scan that sees the key to the `key_valid` pulse is DEBOUNCE_SCANS·3·SCAN_CYCLES + 1 cycles.
- Release latency: same count, to `key` = `KEY_NONE`.
- `key_valid` is never high for two consecutive cycles. At most one pulse occurs per press/release cycle.

## Structure
- Shared package `alarm_clock_pkg`:
  - key-code constants `KEY_NONE`, `KEY_STAR`, `KEY_HASH`
  - FSM state encoding IDLE, DEBOUNCE, PRESSED, RELEASE
  - The display driver uses the same key-code constants.
- Sub-module `keypad_decode`: combinational. Maps (column index, 4-bit active row vector) to a key code and a per-column hit count. The top level accumulates the scan result from it.
- Counter widths come from `$clog2` of SCAN_CYCLES and DEBOUNCE_SCANS+1.

## Test plan
All scenarios use SCAN_CYCLES=4 and DEBOUNCE_SCANS=3 (scan = 12 cycles).
- Reset then idle 100 cycles → `col_n` cycles 110, 101, 011 every 4 cycles; `key` = 4'hA; `key_valid` never high.
- Hold row 2 low only while col 1 is active ("8") → exactly one `key_valid` with `key` = 4'd8, 37 cycles after the first qualifying scan start. `key_held` = 1 while held. `key` returns to 4'hA 37 cycles after release.
- "5" present for 2 scans, released for 1, then held → no pulse during the bounce; one pulse once 3 consecutive scans read 5.
- Hold "1" and "#" simultaneously for 10 scans → no `key_valid`; `key` stays 4'hA.
- Hold "0", then press "3" while still holding "0" → one pulse with `key` = 4'd0 only. After both are released and "3" is pressed alone, one pulse with `key` = 4'd3.
- Assert `reset` for 1 cycle during PRESSED with "*" still held → outputs take reset values; one new pulse with `key` = 4'hB 37 cycles later.
